// File: rtl/ysyx_bus_arb_if.sv
// AXI4 master-side bundle between the bus arbiter and the memory slave.
interface ysyx_bus_arb_if #(
    parameter int unsigned DATA_W = 32
);
    // read address channel
    logic                  arvalid;
    logic                  arready;
    logic [DATA_W-1:0]     araddr;
    logic [3:0]            arid;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    // read data channel
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [3:0]            rid;
    // write address channel
    logic                  awvalid;
    logic                  awready;
    logic [DATA_W-1:0]     awaddr;
    logic [3:0]            awid;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    // write data channel
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;
    // write response channel
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready,
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready,
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp,
        input  bready
    );
endinterface

// File: rtl/ysyx_bus_arb.sv
// Fetch / load-store arbiter onto a single AXI4 master with one
// transaction outstanding. Read beats are forwarded combinationally.
module ysyx_bus_arb #(
    parameter int unsigned DATA_W = 32,
    parameter logic [3:0]  IFU_ID = 4'h0,
    parameter logic [3:0]  LSU_ID = 4'h1
) (
    input  logic                clk,
    input  logic                rst,
    // fetch port
    input  logic [DATA_W-1:0]   ifu_araddr,
    input  logic                ifu_arvalid,
    input  logic                ifu_required,
    input  logic                ifu_burst,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_rvalid,
    // load/store port
    input  logic [DATA_W-1:0]   lsu_araddr,
    input  logic                lsu_arvalid,
    input  logic [2:0]          lsu_arsize,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_rvalid,
    input  logic [DATA_W-1:0]   lsu_awaddr,
    input  logic                lsu_awvalid,
    input  logic [2:0]          lsu_awsize,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_wdone,
    output logic                bus_err_o,
    // AXI4 master
    ysyx_bus_arb_if.master      axi
);

    typedef enum logic [2:0] {
        IDLE, IFU_AR, IFU_R, IFU_HOLD, LSU_AR, LSU_R, LSU_AW, LSU_B
    } state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;

    state_e                state_q;
    logic                  arvalid_q;
    logic [DATA_W-1:0]     araddr_q;
    logic [3:0]            arid_q;
    logic [7:0]            arlen_q;
    logic [2:0]            arsize_q;
    logic                  rready_q;
    logic                  awvalid_q;
    logic [DATA_W-1:0]     awaddr_q;
    logic [2:0]            awsize_q;
    logic                  wvalid_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic                  bready_q;

    logic                  aw_done;
    logic                  w_done;
    logic                  rid_unused;

    // Single outstanding transaction, so the returned ID carries no information.
    assign rid_unused = ^axi.rid;

    // Each write channel is finished once its valid is gone or handshakes now.
    assign aw_done = !awvalid_q || axi.awready;
    assign w_done  = !wvalid_q  || axi.wready;

    // Arbitration FSM; all AXI request-side signals are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arid_q    <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            awsize_q  <= '0;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lsu_awvalid) begin
                        awaddr_q  <= lsu_awaddr;
                        awsize_q  <= lsu_awsize;
                        wdata_q   <= lsu_wdata;
                        wstrb_q   <= lsu_wstrb;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= LSU_AW;
                    end else if (lsu_arvalid) begin
                        araddr_q  <= lsu_araddr;
                        arsize_q  <= lsu_arsize;
                        arid_q    <= LSU_ID;
                        arlen_q   <= '0;
                        arvalid_q <= 1'b1;
                        state_q   <= LSU_AR;
                    end else if (ifu_arvalid) begin
                        araddr_q  <= ifu_araddr;
                        arsize_q  <= 3'b010;
                        arid_q    <= IFU_ID;
                        arlen_q   <= {7'b0, ifu_burst};
                        arvalid_q <= 1'b1;
                        state_q   <= IFU_AR;
                    end
                end
                IFU_AR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= IFU_R;
                    end
                end
                IFU_R: begin
                    if (axi.rvalid && axi.rlast) begin
                        rready_q <= 1'b0;
                        state_q  <= ifu_required ? IFU_HOLD : IDLE;
                    end
                end
                IFU_HOLD: begin
                    // a new fetch beats the release when both arrive together
                    if (ifu_arvalid) begin
                        araddr_q  <= ifu_araddr;
                        arsize_q  <= 3'b010;
                        arid_q    <= IFU_ID;
                        arlen_q   <= {7'b0, ifu_burst};
                        arvalid_q <= 1'b1;
                        state_q   <= IFU_AR;
                    end else if (!ifu_required) begin
                        state_q <= IDLE;
                    end
                end
                LSU_AR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= LSU_R;
                    end
                end
                LSU_R: begin
                    if (axi.rvalid) begin
                        rready_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                LSU_AW: begin
                    if (axi.awready) awvalid_q <= 1'b0;
                    if (axi.wready)  wvalid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= LSU_B;
                    end
                end
                LSU_B: begin
                    if (axi.bvalid) begin
                        bready_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // AXI request-side outputs
    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = araddr_q;
    assign axi.arid    = arid_q;
    assign axi.arlen   = arlen_q;
    assign axi.arsize  = arsize_q;
    assign axi.arburst = BURST_INCR;
    assign axi.rready  = rready_q;
    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = awaddr_q;
    assign axi.awid    = LSU_ID;
    assign axi.awlen   = '0;
    assign axi.awsize  = awsize_q;
    assign axi.awburst = BURST_INCR;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;
    assign axi.bready  = bready_q;

    // Requester-side strobes follow the slave response in the same cycle.
    assign ifu_rdata  = axi.rdata;
    assign lsu_rdata  = axi.rdata;
    assign ifu_rvalid = (state_q == IFU_R) && axi.rvalid;
    assign lsu_rvalid = (state_q == LSU_R) && axi.rvalid;
    assign lsu_wdone  = (state_q == LSU_B) && axi.bvalid;
    assign bus_err_o  = ((ifu_rvalid || lsu_rvalid) && (axi.rresp != 2'b00)) ||
                        (lsu_wdone && (axi.bresp != 2'b00));

endmodule
